// File: rtl/mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_bus_arbiter
// Description : Round-robin arbiter sharing one cache-line memory bus between
//               the I-cache (0) and D-cache (1); one transaction at a time.
//               Define ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 256
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_req_valid,
  input  logic [1:0]        i_req_rw,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  input  logic [LINE_W-1:0] i_req_wdata0,
  input  logic [LINE_W-1:0] i_req_wdata1,
  output logic [1:0]        o_req_ready,
  output logic [LINE_W-1:0] o_req_rdata,
  output logic [1:0]        o_req_err,
  output logic              o_mem_valid,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [LINE_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_rr_last;
  logic              r_grant;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;
  logic              r_mem_valid;
  logic [1:0]        r_req_ready;
  logic              r_busy;

  logic              w_winner;
  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_W-1:0] w_wdata;

  // On a tie the requester that was not served last wins.
  assign w_winner = (&i_req_valid) ? ~r_rr_last : i_req_valid[1];
  assign w_rw     = w_winner ? i_req_rw[1]  : i_req_rw[0];
  assign w_addr   = w_winner ? i_req_addr1  : i_req_addr0;
  assign w_wdata  = w_winner ? i_req_wdata1 : i_req_wdata0;

`ifdef ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT);
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [1:0]         r_req_err;
  assign o_req_err = r_req_err;
`else
  assign o_req_err = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 1'b1;
      r_grant     <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_valid <= 1'b0;
      r_req_ready <= 2'b00;
      r_busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_req_err   <= 2'b00;
`endif
    end else begin
      r_mem_valid <= 1'b0;
      r_req_ready <= 2'b00;
`ifdef ARB_TIMEOUT_EN
      r_req_err   <= 2'b00;
`endif
      case (r_state)
        S_IDLE: begin
          if (|i_req_valid) begin
            r_grant     <= w_winner;
            r_rw        <= w_rw;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_mem_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mem_ready) begin
            r_rdata              <= i_mem_rdata;
            r_req_ready[r_grant] <= 1'b1;
            r_state              <= S_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_wait_cnt == c_CNT_W'(TIMEOUT - 1)) begin
            r_req_err[r_grant] <= 1'b1;
            r_rr_last          <= r_grant;
            r_busy             <= 1'b0;
            r_state            <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_rr_last <= r_grant;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_req_rdata = r_rdata;
  assign o_mem_valid = r_mem_valid;
  assign o_mem_rw    = r_rw;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_bus_arbiter
// Description : Directed bench for mem_bus_arbiter with a line-memory slave
//               model (Mem[i] = i per 64-bit beat).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_rw;
  logic [31:0]  req_addr0;
  logic [31:0]  req_addr1;
  logic [511:0] req_wdata0;
  logic [511:0] req_wdata1;
  logic [1:0]   o_req_ready;
  logic [511:0] o_req_rdata;
  logic [1:0]   o_req_err;
  logic         o_mem_valid;
  logic         o_mem_rw;
  logic [31:0]  o_mem_addr;
  logic [511:0] o_mem_wdata;
  logic         mem_ready;
  logic [511:0] mem_rdata;
  logic         o_busy;
  logic         o_grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_arbiter #(
    .ADDR_W (32),
    .LINE_W (512)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT (16)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .i_req_rw     (req_rw),
    .i_req_addr0  (req_addr0),
    .i_req_addr1  (req_addr1),
    .i_req_wdata0 (req_wdata0),
    .i_req_wdata1 (req_wdata1),
    .o_req_ready  (o_req_ready),
    .o_req_rdata  (o_req_rdata),
    .o_req_err    (o_req_err),
    .o_mem_valid  (o_mem_valid),
    .o_mem_rw     (o_mem_rw),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ready  (mem_ready),
    .i_mem_rdata  (mem_rdata),
    .o_busy       (o_busy),
    .o_grant_id   (o_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: one request at a time, completion two cycles after accept.
  logic [63:0]  mem [0:255];
  logic [1:0]   s_cnt;
  logic         s_rw;
  logic [4:0]   s_line;
  logic [511:0] s_wdata;
  logic         s_stall = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt     <= 2'd0;
      s_rw      <= 1'b0;
      s_line    <= 5'd0;
      s_wdata   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 64'(i);
    end else begin
      mem_ready <= 1'b0;
      if (s_cnt == 2'd0) begin
        if (o_mem_valid && !s_stall) begin
          s_cnt   <= 2'd2;
          s_rw    <= o_mem_rw;
          s_line  <= o_mem_addr[10:6];
          s_wdata <= o_mem_wdata;
        end
      end else begin
        s_cnt <= s_cnt - 2'd1;
        if (s_cnt == 2'd1) begin
          mem_ready <= 1'b1;
          for (int j = 0; j < 8; j++) begin
            if (s_rw) mem[{s_line, 3'(j)}] <= s_wdata[64*j +: 64];
            else      mem_rdata[64*j +: 64] <= mem[{s_line, 3'(j)}];
          end
        end
      end
    end
  end

  // Bus monitor
  int          n_mv = 0;
  int          n_rdy0 = 0;
  int          n_rdy1 = 0;
  int          n_overlap = 0;
  logic        inflight = 1'b0;
  logic [31:0] mon_addr = '0;
  logic        mon_rw = 1'b0;

  always @(negedge clk) begin
    if (o_mem_valid === 1'b1) begin
      n_mv     <= n_mv + 1;
      mon_addr <= o_mem_addr;
      mon_rw   <= o_mem_rw;
      if (inflight) n_overlap <= n_overlap + 1;
      inflight <= 1'b1;
    end else if ((|o_req_ready) || (|o_req_err)) begin
      inflight <= 1'b0;
    end
    if (o_req_ready[0] === 1'b1) n_rdy0 <= n_rdy0 + 1;
    if (o_req_ready[1] === 1'b1) n_rdy1 <= n_rdy1 + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int id, output bit ok, output logic [511:0] rd, output int lat);
    ok  = 1'b0;
    rd  = '0;
    lat = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      lat++;
      if (o_req_ready[id] === 1'b1) begin
        ok = 1'b1;
        rd = o_req_rdata;
      end
    end
  endtask

  task automatic test_reset();
    bit ok; logic [511:0] rd; int lat; bit seen;
    rst_n = 1'b0; req_valid = 2'b11; req_rw = 2'b00;
    req_addr0 = 32'h100; req_addr1 = 32'h140;
    req_wdata0 = '0; req_wdata1 = '0;
    repeat (4) tick();
    n_checks++; if (o_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", o_req_ready); end
    n_checks++; if (o_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got=%b exp=0", o_mem_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    n_checks++; if (o_grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant got=%b exp=0", o_grant_id); end
    n_checks++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", o_mem_addr); end
    n_checks++; if (o_req_rdata !== 512'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", o_req_rdata[63:0]); end
    n_checks++; if (o_req_err !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", o_req_err); end
    n_checks++; if (n_mv !== 0) begin n_fail++; $display("FAIL reset_no_pulse got=%0d exp=0", n_mv); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_busy === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen || o_grant_id !== 1'b0) begin n_fail++; $display("FAIL first_grant got=%b busy_seen=%b exp=0", o_grant_id, seen); end
    wait_ready(0, ok, rd, lat);
    req_valid[0] = 1'b0;
    n_checks++; if (!ok || rd[63:0] !== 64'd32) begin n_fail++; $display("FAIL reset_req0_rdata ok=%b got=%h exp=20", ok, rd[63:0]); end
    wait_ready(1, ok, rd, lat);
    req_valid[1] = 1'b0;
    n_checks++; if (!ok || rd[511:448] !== 64'd47) begin n_fail++; $display("FAIL reset_req1_rdata ok=%b got=%h exp=2f", ok, rd[511:448]); end
    tick();
  endtask

  task automatic test_single_read();
    bit ok; logic [511:0] rd; int lat; int mv0; int r0; int r1;
    mv0 = n_mv; r0 = n_rdy0; r1 = n_rdy1;
    req_rw[0] = 1'b0; req_addr0 = 32'h40; req_valid[0] = 1'b1;
    wait_ready(0, ok, rd, lat);
    req_valid[0] = 1'b0;
    repeat (2) tick();
    n_checks++; if (!ok || lat !== 5) begin n_fail++; $display("FAIL read_latency ok=%b got=%0d exp=5", ok, lat); end
    n_checks++; if (n_mv - mv0 !== 1) begin n_fail++; $display("FAIL read_mem_valid_pulses got=%0d exp=1", n_mv - mv0); end
    n_checks++; if (mon_addr !== 32'h40) begin n_fail++; $display("FAIL read_mem_addr got=%h exp=40", mon_addr); end
    n_checks++; if (n_rdy0 - r0 !== 1 || n_rdy1 - r1 !== 0) begin n_fail++; $display("FAIL read_ready_counts got=%0d/%0d exp=1/0", n_rdy0 - r0, n_rdy1 - r1); end
    n_checks++; if (rd[63:0] !== 64'd8) begin n_fail++; $display("FAIL read_beat0 got=%h exp=8", rd[63:0]); end
    n_checks++; if (rd[511:448] !== 64'd15) begin n_fail++; $display("FAIL read_beat7 got=%h exp=f", rd[511:448]); end
  endtask

  task automatic test_write_read();
    bit ok; logic [511:0] rd; int lat; int r0; int r1;
    r0 = n_rdy0; r1 = n_rdy1;
    req_rw[1] = 1'b1; req_addr1 = 32'h80; req_wdata1 = {64{8'hA5}}; req_valid[1] = 1'b1;
    wait_ready(1, ok, rd, lat);
    req_valid[1] = 1'b0;
    n_checks++; if (!ok || mon_rw !== 1'b1 || mon_addr !== 32'h80) begin n_fail++; $display("FAIL write_issue ok=%b rw=%b addr=%h exp=1/80", ok, mon_rw, mon_addr); end
    tick();
    req_rw[1] = 1'b0; req_valid[1] = 1'b1;
    wait_ready(1, ok, rd, lat);
    req_valid[1] = 1'b0;
    tick();
    n_checks++; if (!ok || rd !== {64{8'hA5}}) begin n_fail++; $display("FAIL write_readback ok=%b got=%h exp=a5a5a5a5a5a5a5a5", ok, rd[63:0]); end
    n_checks++; if (n_rdy0 - r0 !== 0 || n_rdy1 - r1 !== 2) begin n_fail++; $display("FAIL write_ready_counts got=%0d/%0d exp=0/2", n_rdy0 - r0, n_rdy1 - r1); end
  endtask

  task automatic test_contention();
    logic [3:0] order; int k; int mv0;
    order = 4'b0000; k = 0; mv0 = n_mv;
    req_rw = 2'b00; req_addr0 = 32'h40; req_addr1 = 32'h80;
    req_valid = 2'b11;
    for (int i = 0; i < 200 && k < 4; i++) begin
      tick();
      if (|o_req_ready) begin
        order[k] = o_req_ready[1];
        k++;
        if (k == 4) req_valid = 2'b00;
      end
    end
    req_valid = 2'b00;
    repeat (2) tick();
    n_checks++; if (k !== 4 || order !== 4'b1010) begin n_fail++; $display("FAIL contention_order got=%b count=%0d exp=1010", order, k); end
    n_checks++; if (n_mv - mv0 !== 4) begin n_fail++; $display("FAIL contention_pulses got=%0d exp=4", n_mv - mv0); end
    n_checks++; if (n_overlap !== 0) begin n_fail++; $display("FAIL contention_overlap got=%0d exp=0", n_overlap); end
  endtask

  task automatic test_stability();
    bit ok; logic [511:0] rd; int lat; bit seen; bit stable; bit done;
    logic [511:0] pat;
    pat = {8{64'h0123_4567_89AB_CDEF}};
    req_rw[0] = 1'b1; req_addr0 = 32'hC0; req_wdata0 = pat; req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_mem_valid === 1'b1) seen = 1'b1;
    end
    req_addr0 = 32'h1C0; req_wdata0 = ~pat;
    stable = 1'b1; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (o_mem_addr !== 32'hC0 || o_mem_wdata !== pat) stable = 1'b0;
      if (o_req_ready[0] === 1'b1) done = 1'b1;
    end
    req_valid[0] = 1'b0;
    n_checks++; if (!seen || !done || !stable) begin n_fail++; $display("FAIL stability seen=%b done=%b stable=%b exp=1/1/1", seen, done, stable); end
    tick();
    req_rw[0] = 1'b0; req_addr0 = 32'hC0; req_valid[0] = 1'b1;
    wait_ready(0, ok, rd, lat);
    req_valid[0] = 1'b0;
    tick();
    n_checks++; if (!ok || rd !== pat) begin n_fail++; $display("FAIL stability_readback ok=%b got=%h exp=0123456789abcdef", ok, rd[63:0]); end
  endtask

  task automatic test_valid_drop();
    bit ok; logic [511:0] rd; int lat;
    req_rw[0] = 1'b0; req_addr0 = 32'h40; req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    wait_ready(0, ok, rd, lat);
    tick();
    n_checks++; if (!ok || rd[63:0] !== 64'd8) begin n_fail++; $display("FAIL valid_drop ok=%b got=%h exp=8", ok, rd[63:0]); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen; bit got; int cyc; int r1;
    r1 = n_rdy1;
    s_stall = 1'b1;
    req_rw[1] = 1'b0; req_addr1 = 32'h40; req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (o_mem_valid === 1'b1) seen = 1'b1;
    end
    got = 1'b0; cyc = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      cyc++;
      if (o_req_err[1] === 1'b1) got = 1'b1;
    end
    req_valid[1] = 1'b0;
    n_checks++; if (!seen || !got || cyc !== 17) begin n_fail++; $display("FAIL timeout_cycles got=%0d err_seen=%b exp=17", cyc, got); end
    n_checks++; if (o_busy !== 1'b0 || n_rdy1 - r1 !== 0) begin n_fail++; $display("FAIL timeout_idle busy=%b ready_pulses=%0d exp=0/0", o_busy, n_rdy1 - r1); end
    s_stall = 1'b0;
    repeat (2) tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_stability();
    test_valid_drop();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
